memy_reader: RTL
================

# memy_reader

Read-side sequencer for the Y-operand memory of the convolution datapath. On a start pulse it issues sequential reads from address 0 to size_y-1 against the memory's one-cycle registered read port. It returns the samples as a valid/ready stream with a last flag, absorbing downstream backpressure in a small internal FIFO. It sits between memY and the convolution MAC/control unit and replaces ad-hoc address counters in the datapath.

## Interface

- DATA_WIDTH, 8, bits per sample
- ADDR_WIDTH, 3, memory address width
- SIZE, 5, number of words physically present in the memory

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to stream a block; ignored while busy
- size_y  in  ADDR_WIDTH  number of samples to stream; sampled on accepted start
- busy  out  1  block in progress
- done  out  1  one-cycle pulse after final sample handshake
- mem_address  out  ADDR_WIDTH  read address to memory
- mem_readEnable  out  1  read strobe to memory
- mem_readData  in  DATA_WIDTH  memory read data, valid the cycle after mem_readEnable
- out_data  out  DATA_WIDTH  streamed sample
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_last  out  1  marks final sample of block

## Operation

- States: IDLE, RUN, DONE.
- IDLE: start=1 captures n = min(size_y, SIZE) and goes to RUN. If n=0, it goes to DONE instead.
- RUN: busy=1.
  - Issue counter rd_addr starts at 0.
  - Internal FIFO depth 3; in-flight counter infl holds 0..1.
  - A read is issued in a cycle iff rd_addr<n and count+infl<3. This ignores a same-cycle pop and guarantees no FIFO overflow.
  - On issue: mem_readEnable=1, mem_address=rd_addr; rd_addr increments and infl increments.
  - The cycle after an issue, mem_readData is written into the FIFO and infl decrements. Issue and capture in the same cycle leave infl unchanged.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last=1 when the head is sample index n-1. A 3-bit output index counter tracks this.
  - Handshake (out_valid & out_ready) pops the head. out_data/out_last hold stable while out_valid=1 and out_ready=0.
  - Last handshake (out_last=1) moves the FSM to DONE.
- DONE: one cycle; done=1, busy=0; then IDLE.
- start while busy or in DONE is ignored and not queued.
- mem_readEnable=0 and mem_address=0 whenever no read is issued.
- The block never writes memory. Write-side ports of the memory are driven elsewhere.
- Reset at any time returns to IDLE. It flushes the FIFO, infl, and counters. The read issued in the reset cycle is discarded; memory contents are unaffected.

## Timing

- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_readEnable=0, mem_address=0.
- Start sampled at edge of cycle 0:
  - cycle 1: mem_readEnable=1, addr 0
  - cycle 2: memory presents M[0], captured at end of cycle
  - cycle 3: out_valid=1 with M[0]
- Start-to-first-valid latency: 3 cycles.
- With out_ready held high:
  - one sample per cycle
  - samples at cycles 3..n+2
  - done at cycle n+3
  - busy high cycles 1..n+2
- Backpressure: at most 3 samples buffered; issue resumes the cycle after a pop frees credit. No sample is lost or duplicated.
- n=0: done pulses at cycle 1 with no reads and no out_valid.
- size_y>SIZE is clamped to SIZE; addresses never exceed SIZE-1.
- A start arriving in the DONE cycle is dropped. A start in the following IDLE cycle is accepted.

## Test plan

- Memory preloaded 0x11,0x22,0x33,0x44,0x55; size_y=5; out_ready=1 -> out_data 11..55 on cycles 3..7, out_last only with 0x55, done at cycle 8.
- Same data; out_ready toggled 1,0,0,1 pattern -> exact in-order sequence 11..55, mem_readEnable stalls when 3 buffered, data stable while stalled.
- size_y=0 -> no mem_readEnable, no out_valid, done one cycle after start; size_y=7 -> exactly 5 samples, max address 4.
- start pulsed again during RUN and in the DONE cycle -> ignored; a second block requested afterwards in IDLE streams normally from address 0.
- rst asserted mid-block with 2 samples buffered -> next cycle busy=0, out_valid=0, mem_readEnable=0; new start streams from address 0.
- out_ready low for 10 cycles from start with size_y=5 -> exactly 3 reads issued, remaining 2 issued only after pops; final order 11..55.

Source files
------------

// File: rtl/memy_reader.sv
// Y-operand read sequencer: streams memY[0..n-1] as valid/ready with last flag.
// First sample 3 cycles after start; a 3-entry FIFO absorbs stalls and gates read issue.

// Small synchronous FIFO; push/pop in the same cycle is allowed.
// Zero-latency head; push when full and pop when empty are ignored.
module memy_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = store[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module memy_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int SIZE       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] size_y,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_readEnable,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [NW-1:0] SIZE_N = NW'(SIZE);

  logic [1:0]            state;
  logic [NW-1:0]         n;
  logic [NW-1:0]         n_start;
  logic [NW-1:0]         rd_addr;
  logic                  infl;
  logic [ADDR_WIDTH-1:0] out_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  issue;
  logic                  handshake;

  assign n_start = ({1'b0, size_y} > SIZE_N) ? SIZE_N : {1'b0, size_y};

  // Credit check counts the in-flight read but not a same-cycle pop.
  assign issue = (state == RUN) && (rd_addr < n) &&
                 (({1'b0, fifo_count} + {2'b00, infl}) < 3'd3);

  assign mem_readEnable = issue;
  assign mem_address    = issue ? rd_addr[ADDR_WIDTH-1:0] : '0;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_last  = out_valid && (out_idx == last_idx);
  assign handshake = out_valid && out_ready;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  memy_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(3),
    .CW   (2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (infl),
    .push_data(mem_readData),
    .pop      (handshake),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n        <= '0;
      rd_addr  <= '0;
      infl     <= 1'b0;
      out_idx  <= '0;
      last_idx <= '0;
    end else begin
      // Read data arrives exactly one cycle after issue, so infl mirrors last cycle's issue.
      infl <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            n        <= n_start;
            last_idx <= ADDR_WIDTH'(n_start - NW'(1));
            rd_addr  <= '0;
            out_idx  <= '0;
            state    <= (n_start == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) rd_addr <= rd_addr + NW'(1);
          if (handshake) begin
            out_idx <= out_idx + ADDR_WIDTH'(1);
            if (out_last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
